snap_capture_ctrl: RTL and testbench

Parametrised snapshot capture controller. It drives port A (write side) of a snapshot block RAM: bram_we, bram_en_a, bram_addr and bram_wr_data.

---
 rtl/snap_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_snap_capture_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: drives the write port of a snapshot BRAM in one-shot
// or circular pre-trigger mode and reports trigger/last addresses for buffer unwrap.
module snap_capture_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter bit USE_VALID  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  circ,
  input  logic                  trig,
  input  logic [ADDR_WIDTH-1:0] post_len,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  bram_we,
  output logic                  bram_en_a,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] last_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  circ_q, circ_d;
  logic [ADDR_WIDTH-1:0] post_len_q, post_len_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  qual;

  assign qual = !USE_VALID || din_valid;

  always_comb begin
    state_d     = state_q;
    circ_d      = circ_q;
    post_len_d  = post_len_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    trig_addr_d = trig_addr_q;
    last_addr_d = last_addr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    // arm wins over everything, including a sample arriving in the same cycle
    if (arm) begin
      state_d    = S_ARMED;
      circ_d     = circ;
      post_len_d = post_len;
      ptr_d      = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (qual && (circ_q || trig)) begin
            we_d   = 1'b1;
            addr_d = ptr_q;
            data_d = din;
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            if (trig) begin
              trig_addr_d = ptr_q;
              if (circ_q && post_len_q == '0) begin
                last_addr_d = ptr_q;
                state_d     = S_DONE;
              end else begin
                // one-shot fills the whole buffer: trigger sample plus 2**ADDR_WIDTH-1 more
                remain_d = circ_q ? post_len_q : '1;
                state_d  = S_CAPTURE;
              end
            end
          end
        end
        S_CAPTURE: begin
          if (qual) begin
            we_d     = 1'b1;
            addr_d   = ptr_q;
            data_d   = din;
            ptr_d    = ptr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - ADDR_WIDTH'(1);
            if (remain_q == ADDR_WIDTH'(1)) begin
              last_addr_d = ptr_q;
              state_d     = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      circ_q      <= 1'b0;
      post_len_q  <= '0;
      ptr_q       <= '0;
      remain_q    <= '0;
      trig_addr_q <= '0;
      last_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      circ_q      <= circ_d;
      post_len_q  <= post_len_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      trig_addr_q <= trig_addr_d;
      last_addr_q <= last_addr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_we      = we_q;
  assign bram_en_a    = we_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign trig_addr    = trig_addr_q;
  assign last_addr    = last_addr_q;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl: one-shot, circular, valid gaps, re-arm and
// asynchronous reset, with a negedge write logger feeding the checks.
module tb_snap_capture_ctrl;

  localparam int DW = 128;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, arm, circ, trig, din_valid;
  logic [AW-1:0] post_len;
  logic [DW-1:0] din;
  logic          bram_we, bram_en_a, busy, done;
  logic [AW-1:0] bram_addr, trig_addr, last_addr;
  logic [DW-1:0] bram_wr_data;

  always #5 clk = ~clk;

  snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USE_VALID(1'b1)) dut (
    .clk(clk), .rst(rst), .arm(arm), .circ(circ), .trig(trig), .post_len(post_len),
    .din(din), .din_valid(din_valid), .bram_we(bram_we), .bram_en_a(bram_en_a),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .busy(busy), .done(done),
    .trig_addr(trig_addr), .last_addr(last_addr)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cnt      = 0;
  int     en_err   = 0;
  int     errs;
  int     t0, t1;
  int     wr_addr[$];
  longint wr_data[$];
  bit     wr_done[$];
  bit     wr_busy[$];
  longint exp_data[$];

  always @(negedge clk) begin
    if (bram_en_a !== bram_we) en_err++;
    if (bram_we === 1'b1) begin
      wr_addr.push_back(int'(bram_addr));
      wr_data.push_back(longint'(bram_wr_data[63:0]));
      wr_done.push_back(done);
      wr_busy.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit a, input bit t, input bit v);
    arm       = a;
    trig      = t;
    din_valid = v;
    din       = DW'(cnt);
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
    wr_busy.delete();
    exp_data.delete();
  endtask

  function automatic longint qa(input int i);
    if (i < wr_addr.size()) return longint'(wr_addr[i]);
    return -1;
  endfunction

  function automatic longint qd(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return -1;
  endfunction

  function automatic longint qdn(input int i);
    if (i < wr_done.size()) return longint'(wr_done[i]);
    return -1;
  endfunction

  function automatic longint qb(input int i);
    if (i < wr_busy.size()) return longint'(wr_busy[i]);
    return -1;
  endfunction

  initial begin
    rst = 1'b1; arm = 1'b0; circ = 1'b0; trig = 1'b0; din_valid = 1'b0;
    post_len = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_wr_data[63:0], 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_last_addr", last_addr, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // one-shot, trigger on sample 20, data = counter
    clear_log();
    cnt = 0; circ = 1'b0;
    drive(1, 0, 1);
    repeat (19) drive(0, 0, 1);
    drive(0, 1, 1);
    repeat (1033) drive(0, 0, 1);
    settle();
    chk("t1_nwr", wr_addr.size(), 1024);
    chk("t1_first_addr", qa(0), 0);
    chk("t1_first_data", qd(0), 20);
    chk("t1_last_addr_wr", qa(1023), 1023);
    chk("t1_last_data", qd(1023), 1043);
    errs = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != longint'(20 + i)) errs++;
    chk("t1_seq", errs, 0);
    chk("t1_done_pre", qdn(1022), 0);
    chk("t1_done_final", qdn(1023), 1);
    chk("t1_busy_final", qb(1023), 0);
    chk("t1_trig_addr", trig_addr, 0);
    chk("t1_last_addr", last_addr, 1023);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);

    // circular, post_len=100, 1500 pre-trigger samples
    clear_log();
    circ = 1'b1; post_len = AW'(100);
    t0 = cnt;
    drive(1, 0, 1);
    repeat (1500) drive(0, 0, 1);
    drive(0, 1, 1);
    repeat (105) drive(0, 0, 1);
    settle();
    chk("t2_nwr", wr_addr.size(), 1601);
    chk("t2_first_addr", qa(0), 0);
    chk("t2_first_data", qd(0), longint'(t0 + 1));
    chk("t2_wrap_addr", qa(1024), 0);
    chk("t2_trig_wr_addr", qa(1500), 476);
    chk("t2_trig_wr_data", qd(1500), longint'(t0 + 1501));
    chk("t2_final_wr_addr", qa(1600), 576);
    chk("t2_done_pre", qdn(1599), 0);
    chk("t2_done_final", qdn(1600), 1);
    chk("t2_trig_addr", trig_addr, 476);
    chk("t2_last_addr", last_addr, 576);
    chk("t2_done", done, 1);

    // circular, post_len=0: trigger sample is the only write
    clear_log();
    circ = 1'b1; post_len = '0;
    drive(1, 0, 1);
    drive(0, 1, 0);
    drive(0, 1, 0);
    t0 = cnt;
    drive(0, 1, 1);
    repeat (5) drive(0, 1, 1);
    settle();
    chk("t3_nwr", wr_addr.size(), 1);
    chk("t3_addr", qa(0), 0);
    chk("t3_data", qd(0), longint'(t0));
    chk("t3_done_with_wr", qdn(0), 1);
    chk("t3_busy_with_wr", qb(0), 0);
    chk("t3_trig_addr", trig_addr, 0);
    chk("t3_last_addr", last_addr, 0);

    // one-shot with din_valid toggling
    clear_log();
    circ = 1'b0; post_len = AW'(5);
    drive(1, 0, 1);
    exp_data.push_back(longint'(cnt));
    drive(0, 1, 1);
    for (int i = 0; i < 2046; i++) begin
      if (i % 2 == 1) exp_data.push_back(longint'(cnt));
      drive(0, 0, (i % 2) == 1);
    end
    repeat (10) drive(0, 0, 1);
    settle();
    chk("t4_nwr", wr_addr.size(), 1024);
    errs = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || i >= exp_data.size() || wr_data[i] != exp_data[i]) errs++;
    chk("t4_seq", errs, 0);
    chk("t4_done_pre", qdn(1022), 0);
    chk("t4_done_final", qdn(1023), 1);
    chk("t4_last_addr", last_addr, 1023);
    chk("t4_done", done, 1);

    // trig held through arm, then re-arm at write 300
    clear_log();
    circ = 1'b0; post_len = AW'(7);
    drive(1, 1, 1);
    t0 = cnt;
    drive(0, 1, 1);
    repeat (299) drive(0, 0, 1);
    settle();
    chk("t5_nwr", wr_addr.size(), 300);
    chk("t5_first_addr", qa(0), 0);
    chk("t5_first_data", qd(0), longint'(t0));
    chk("t5_addr299", qa(299), 299);
    drive(1, 0, 1);
    repeat (10) drive(0, 0, 1);
    settle();
    chk("t6_nwr_after_arm", wr_addr.size(), 300);
    chk("t6_busy", busy, 1);
    chk("t6_done", done, 0);
    chk("t6_last_addr_hold", last_addr, 1023);
    t1 = cnt;
    drive(0, 1, 1);
    settle();
    chk("t6_nwr_retrig", wr_addr.size(), 301);
    chk("t6_retrig_addr", qa(300), 0);
    chk("t6_retrig_data", qd(300), longint'(t1));
    repeat (4) drive(0, 0, 1);
    settle();
    chk("t6_pre_rst_addr", bram_addr, 4);

    // asynchronous reset mid-capture, away from any clock edge
    rst = 1'b1;
    #1;
    chk("t7_we", bram_we, 0);
    chk("t7_en", bram_en_a, 0);
    chk("t7_addr", bram_addr, 0);
    chk("t7_data", bram_wr_data[63:0], 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_trig_addr", trig_addr, 0);
    chk("t7_last_addr", last_addr, 0);
    repeat (3) drive(0, 1, 1);
    rst = 1'b0;
    repeat (5) drive(0, 1, 1);
    settle();
    chk("t7_nwr_idle", wr_addr.size(), 305);
    chk("t7_idle_busy", busy, 0);
    chk("t7_idle_done", done, 0);
    chk("en_matches_we", en_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
